// File: rtl/point_scan_driver.sv
// Double-buffered 16x16 point bitmap with a row-multiplexed LED scan.
// Define LED_SCAN_BLANK_EN to insert BLANK_CYCLES all-off cycles after each row.
module point_scan_driver #(
    parameter int DWELL_CYCLES = 64,
    parameter int BLANK_CYCLES = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  point_coord,
    input  logic        point_enable,
    input  logic        frame_tick,
    output logic [15:0] row_sel,
    output logic [15:0] col_data,
    output logic [7:0]  frame_points
);

    localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
`ifdef LED_SCAN_BLANK_EN
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
`endif

    typedef enum logic {S_BLANK, S_DRIVE} state_t;

    logic [1:0][15:0][15:0] bitmap;
    logic [1:0][15:0]       row_valid;
    logic                   front_sel;
    logic                   back_sel;
    logic [7:0]             back_cnt;
    logic [7:0]             cnt_next;
    logic [3:0]             pt_row;
    logic [15:0]            pt_mask;

    state_t           state, state_nxt;
    logic [3:0]       row_idx, row_idx_nxt;
    logic [CNT_W-1:0] dwell_cnt, dwell_nxt;
    logic [15:0]      row_sel_nxt, col_nxt;
    logic             blank_done;

    assign back_sel = ~front_sel;
    assign pt_row   = point_coord[7:4];
    assign pt_mask  = 16'(1) << point_coord[3:0];
    assign cnt_next = (point_enable && back_cnt != 8'hFF) ? back_cnt + 8'd1 : back_cnt;

    // Clearing row_valid is the single-cycle bank wipe; stale bitmap bits stay masked.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            row_valid    <= '0;
            front_sel    <= 1'b0;
            back_cnt     <= '0;
            frame_points <= '0;
        end else begin
            if (frame_tick) begin
                row_valid[front_sel] <= '0;
                front_sel            <= ~front_sel;
                frame_points         <= cnt_next;
                back_cnt             <= '0;
            end else begin
                back_cnt <= cnt_next;
            end
            if (point_enable)
                row_valid[back_sel][pt_row] <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (point_enable)
            bitmap[back_sel][pt_row] <= (row_valid[back_sel][pt_row] ?
                                         bitmap[back_sel][pt_row] : 16'h0000) | pt_mask;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_BLANK;
            row_idx   <= '0;
            dwell_cnt <= '0;
            row_sel   <= '0;
            col_data  <= '0;
        end else begin
            state     <= state_nxt;
            row_idx   <= row_idx_nxt;
            dwell_cnt <= dwell_nxt;
            row_sel   <= row_sel_nxt;
            col_data  <= col_nxt;
        end
    end

    // Row data is latched only at row entry, so a mid-row swap waits for the next row.
    always_comb begin
        state_nxt   = state;
        row_idx_nxt = row_idx;
        dwell_nxt   = dwell_cnt;
        row_sel_nxt = row_sel;
        col_nxt     = col_data;
`ifdef LED_SCAN_BLANK_EN
        blank_done  = (dwell_cnt == BLANK_LAST);
`else
        blank_done  = 1'b1;
`endif
        unique case (state)
            S_BLANK: begin
                if (blank_done) begin
                    state_nxt   = S_DRIVE;
                    dwell_nxt   = '0;
                    row_sel_nxt = 16'(1) << row_idx;
                    col_nxt     = row_valid[front_sel][row_idx] ?
                                  bitmap[front_sel][row_idx] : 16'h0000;
                end else begin
                    dwell_nxt = dwell_cnt + CNT_W'(1);
                end
            end
            S_DRIVE: begin
                if (dwell_cnt == DWELL_LAST) begin
                    dwell_nxt   = '0;
                    row_idx_nxt = row_idx + 4'd1;
`ifdef LED_SCAN_BLANK_EN
                    state_nxt   = S_BLANK;
                    row_sel_nxt = '0;
                    col_nxt     = '0;
`else
                    row_sel_nxt = 16'(1) << row_idx_nxt;
                    col_nxt     = row_valid[front_sel][row_idx_nxt] ?
                                  bitmap[front_sel][row_idx_nxt] : 16'h0000;
`endif
                end else begin
                    dwell_nxt = dwell_cnt + CNT_W'(1);
                end
            end
            default: state_nxt = S_BLANK;
        endcase
    end

endmodule

// File: tb/tb_point_scan_driver.sv
// Directed bench for point_scan_driver: table of single-frame vectors plus
// hand-written sequences for swap/point collision, saturation, mid-row swap and reset.
module tb_point_scan_driver;

    localparam int DWELL = 8;
    localparam int BLANK = 2;
`ifdef LED_SCAN_BLANK_EN
    localparam int EXP_OFF   = BLANK;
    localparam int EXP_START = BLANK;
`else
    localparam int EXP_OFF   = 0;
    localparam int EXP_START = 1;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  point_coord = '0;
    logic        point_enable = 1'b0;
    logic        frame_tick = 1'b0;
    logic [15:0] row_sel;
    logic [15:0] col_data;
    logic [7:0]  frame_points;

    int n_chk = 0;
    int n_fail = 0;

    point_scan_driver #(.DWELL_CYCLES(DWELL), .BLANK_CYCLES(BLANK)) dut (
        .clock(clock), .reset(reset), .point_coord(point_coord),
        .point_enable(point_enable), .frame_tick(frame_tick),
        .row_sel(row_sel), .col_data(col_data), .frame_points(frame_points)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          n;
        logic [7:0]  p0, p1, p2;
        int          row;
        logic [15:0] col;
        logic [7:0]  fp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [15:0] onehot(input int r);
        logic [15:0] v;
        v = 16'(1) << r;
        return v;
    endfunction

    task automatic point(input logic [7:0] c);
        @(negedge clock);
        point_coord = c; point_enable = 1'b1;
        @(negedge clock);
        point_enable = 1'b0;
    endtask

    task automatic tick();
        @(negedge clock);
        frame_tick = 1'b1;
        @(negedge clock);
        frame_tick = 1'b0;
    endtask

    task automatic tick_point(input logic [7:0] c);
        @(negedge clock);
        frame_tick = 1'b1; point_coord = c; point_enable = 1'b1;
        @(negedge clock);
        frame_tick = 1'b0; point_enable = 1'b0;
    endtask

    // Waits for a fresh entry into row r (row must first be seen not driven).
    task automatic wait_row(input int r);
        bit left = 1'b0;
        bit ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            if (row_sel != onehot(r)) left = 1'b1;
            else if (left) begin ok = 1'b1; break; end
        end
        chk($sformatf("row%0d_entry", r), 32'(ok), 32'd1);
    endtask

    vec_t vecs[7];

    initial begin
        int n, on, off;
        vecs[0] = '{3, 8'h23, 8'h25, 8'h23, 2,  16'h0028, 8'd3};
        vecs[1] = '{1, 8'hFF, 8'h00, 8'h00, 15, 16'h8000, 8'd1};
        vecs[2] = '{1, 8'hFF, 8'h00, 8'h00, 0,  16'h0000, 8'd1};
        vecs[3] = '{3, 8'h00, 8'h0F, 8'h07, 0,  16'h8081, 8'd3};
        vecs[4] = '{2, 8'h31, 8'h42, 8'h00, 3,  16'h0002, 8'd2};
        vecs[5] = '{0, 8'h00, 8'h00, 8'h00, 7,  16'h0000, 8'd0};
        vecs[6] = '{1, 8'h21, 8'h00, 8'h00, 2,  16'h0002, 8'd1};

        repeat (3) @(negedge clock);
        chk("reset_row_sel", 32'(row_sel), 32'h0);
        chk("reset_col_data", 32'(col_data), 32'h0);
        chk("reset_frame_points", 32'(frame_points), 32'h0);

        reset = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            n++;
            if (row_sel != 16'h0) break;
        end
        chk("startup_cycles", 32'(n), 32'(EXP_START));
        chk("startup_row0", 32'(row_sel), 32'h0001);

        // Empty frame sweep including the 15 -> 0 wrap.
        tick();
        chk("empty_frame_points", 32'(frame_points), 32'h0);
        for (int r = 1; r <= 16; r++) begin
            wait_row(r % 16);
            chk($sformatf("empty_col_row%0d", r % 16), 32'(col_data), 32'h0);
        end

        wait_row(3);
        on = 1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (row_sel == 16'h0008) on++;
            else break;
        end
        off = 0;
        while (row_sel == 16'h0 && off < 50) begin
            off++;
            @(negedge clock);
        end
        chk("dwell_cycles", 32'(on), 32'(DWELL));
        chk("blank_cycles", 32'(off), 32'(EXP_OFF));
        chk("next_row_after_3", 32'(row_sel), 32'h0010);

        for (int v = 0; v < 7; v++) begin
            if (vecs[v].n > 0) point(vecs[v].p0);
            if (vecs[v].n > 1) point(vecs[v].p1);
            if (vecs[v].n > 2) point(vecs[v].p2);
            tick();
            chk($sformatf("vec%0d_frame_points", v), 32'(frame_points), 32'(vecs[v].fp));
            wait_row(vecs[v].row);
            chk($sformatf("vec%0d_col_data", v), 32'(col_data), 32'(vecs[v].col));
        end

        // Point in the same cycle as the swap lands in the frame being shown.
        point(8'h12);
        tick_point(8'h11);
        chk("collide_frame_points", 32'(frame_points), 32'd2);
        wait_row(1);
        chk("collide_col_row1", 32'(col_data), 32'h0006);
        tick();
        chk("after_collide_points", 32'(frame_points), 32'd0);
        wait_row(1);
        chk("after_collide_row1", 32'(col_data), 32'h0000);

        @(negedge clock);
        point_enable = 1'b1;
        for (int i = 0; i < 300; i++) begin
            point_coord = 8'(i);
            @(negedge clock);
        end
        point_enable = 1'b0;
        tick();
        chk("saturated_points", 32'(frame_points), 32'd255);
        tick();
        chk("post_sat_points", 32'(frame_points), 32'd0);

        // Swap in the middle of row 5 must not disturb the latched columns.
        point(8'h5A);
        point(8'h6A);
        wait_row(5);
        chk("midrow_before", 32'(col_data), 32'h0000);
        tick();
        chk("midrow_row_sel", 32'(row_sel), 32'h0020);
        chk("midrow_col_hold", 32'(col_data), 32'h0000);
        repeat (3) @(negedge clock);
        chk("midrow_col_hold2", 32'(col_data), 32'h0000);
        wait_row(6);
        chk("midrow_row6", 32'(col_data), 32'h0400);
        chk("midrow_points", 32'(frame_points), 32'd2);
        wait_row(5);
        chk("midrow_row5_next", 32'(col_data), 32'h0400);

        // Reset mid-row: outputs drop immediately and all points are lost.
        point(8'h5B);
        wait_row(5);
        chk("prereset_col", 32'(col_data), 32'h0400);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_row_sel", 32'(row_sel), 32'h0);
        chk("async_reset_col", 32'(col_data), 32'h0);
        chk("async_reset_points", 32'(frame_points), 32'h0);
        @(negedge clock);
        reset = 1'b0;
        tick();
        chk("postreset_points", 32'(frame_points), 32'h0);
        wait_row(5);
        chk("postreset_row5", 32'(col_data), 32'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
